xx02_mm_req_master: RTL

Memory-mapped request initiator that drives the 14-bit-address / 64-bit-data MM bus into the xx02 global address decoder. It accepts single read/write requests from the PCIe application request path. It issues one-cycle MM write or read strobes and waits for the returned read-data-valid. Each read produces a tagged completion back to the request path, with an optional timeout for unanswered reads.

---
 rtl/xx02_mm_req_master.sv | 133 +++++++++++++
 1 files changed

// File: rtl/xx02_mm_req_master.sv
// xx02_mm_req_master: MM bus request initiator for the xx02 global address decoder.
// Accepts single read/write requests and issues one-cycle MM strobes.
// Each read is returned as a tagged completion.
// Optional feature macro: MM_RD_TIMEOUT_EN adds a read-wait counter and a timeout
// completion. When it is undefined, a read waits indefinitely for data.
module xx02_mm_req_master #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [63:0] ERR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iREQ_V,
    output logic        oREQ_RDY,
    input  logic        iREQ_WR,
    input  logic [13:0] iREQ_ADDR,
    input  logic [63:0] iREQ_WDATA,
    input  logic [7:0]  iREQ_TAG,
    output logic        oCPL_V,
    input  logic        iCPL_RDY,
    output logic [63:0] oCPL_DATA,
    output logic [7:0]  oCPL_TAG,
    output logic        oCPL_ERR,
    output logic [13:0] oMM_ADDR,
    output logic        oMM_WR_EN,
    output logic        oMM_RD_EN,
    output logic [63:0] oMM_WR_DATA,
    input  logic [63:0] iMM_RD_DATA,
    input  logic        iMM_RD_DATA_V,
    output logic        oSTRAY
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, CPL} state_t;

    state_t     state, state_nx;
    logic       req_xfer;
    logic       rd_tmo;
    logic       rd_end;
    logic       req_wr_q;
    logic [7:0] req_tag_q;

    // Reject an out-of-range timeout at elaboration.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..65535");
    end

    assign req_xfer = iREQ_V & oREQ_RDY;
    assign rd_end   = (state == WAIT_RD) & (iMM_RD_DATA_V | rd_tmo);

`ifdef MM_RD_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Wait counter holds the number of the current WAIT_RD cycle, starting at 1, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= 16'd1;
        end else if (state == WAIT_RD && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign rd_tmo = (wait_cnt == 16'(TIMEOUT_CYC));
`else
    assign rd_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_xfer) state_nx = ISSUE;
            ISSUE:   state_nx = req_wr_q ? IDLE : WAIT_RD;
            WAIT_RD: if (iMM_RD_DATA_V || rd_tmo) state_nx = CPL;
            CPL:     if (iCPL_RDY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs: request capture, MM strobes, completion and stray detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oREQ_RDY    <= 1'b0;
            oMM_ADDR    <= '0;
            oMM_WR_DATA <= '0;
            oMM_WR_EN   <= 1'b0;
            oMM_RD_EN   <= 1'b0;
            req_wr_q    <= 1'b0;
            req_tag_q   <= '0;
            oCPL_V      <= 1'b0;
            oCPL_DATA   <= '0;
            oCPL_TAG    <= '0;
            oCPL_ERR    <= 1'b0;
            oSTRAY      <= 1'b0;
        end else begin
            oREQ_RDY  <= (state_nx == IDLE);
            oMM_WR_EN <= 1'b0;
            oMM_RD_EN <= 1'b0;
            oSTRAY    <= iMM_RD_DATA_V & (state != WAIT_RD);
            if (state == IDLE && req_xfer) begin
                oMM_ADDR    <= iREQ_ADDR;
                oMM_WR_DATA <= iREQ_WDATA;
                req_wr_q    <= iREQ_WR;
                req_tag_q   <= iREQ_TAG;
                oMM_WR_EN   <= iREQ_WR;
                oMM_RD_EN   <= ~iREQ_WR;
            end
            if (rd_end) begin
                oCPL_V   <= 1'b1;
                oCPL_TAG <= req_tag_q;
                if (iMM_RD_DATA_V) begin
                    oCPL_DATA <= iMM_RD_DATA;
                    oCPL_ERR  <= 1'b0;
                end else begin
                    oCPL_DATA <= ERR_PATTERN;
                    oCPL_ERR  <= 1'b1;
                end
            end else if (oCPL_V && iCPL_RDY) begin
                oCPL_V <= 1'b0;
            end
        end
    end

endmodule
